pong_draw_arbiter: RTL and testbench

Shares the single VGA adapter write port (x, y, colour, plot) among three sprite requesters: paddle 0, paddle 1 and the ball. A granted requester gets its old rectangle erased to the background colour and its new rectangle drawn in the foreground colour, one pixel per clock. Requesters are served round-robin. The block sits between the per-object datapaths and the vga_adapter instance in the pong top level.

---
 rtl/pong_draw_arbiter.sv | 275 +++++++++++++++++++++++++++
 tb/tb_pong_draw_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pong_draw_arbiter.sv
// Round-robin arbiter sharing the VGA adapter write port among paddle 0,
// paddle 1 and the ball. The served sprite's old rectangle is erased, then its
// new rectangle is drawn, one pixel per clock. Every output is registered.
module pong_draw_arbiter #(
    parameter int unsigned W0        = 4,
    parameter int unsigned H0        = 32,
    parameter int unsigned W1        = 4,
    parameter int unsigned H1        = 32,
    parameter int unsigned W2        = 4,
    parameter int unsigned H2        = 4,
    parameter logic [2:0]  FG_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [26:0] old_x,
    input  logic [23:0] old_y,
    input  logic [26:0] new_x,
    input  logic [23:0] new_y,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam logic [XW-1:0] WM1_0 = XW'(W0 - 1);
    localparam logic [YW-1:0] HM1_0 = YW'(H0 - 1);
    localparam logic [XW-1:0] WM1_1 = XW'(W1 - 1);
    localparam logic [YW-1:0] HM1_1 = YW'(H1 - 1);
    localparam logic [XW-1:0] WM1_2 = XW'(W2 - 1);
    localparam logic [YW-1:0] HM1_2 = YW'(H2 - 1);
    localparam logic [XW:0]   X_LIMIT = (XW+1)'(320);
    localparam logic [YW:0]   Y_LIMIT = (YW+1)'(240);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_ERASE = 3'd2,
        S_DRAW  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d, sel_q, sel_d;
    logic [XW-1:0]   ox_q, ox_d, nx_q, nx_d, wm1_q, wm1_d, dx_q, dx_d;
    logic [YW-1:0]   oy_q, oy_d, ny_q, ny_d, hm1_q, hm1_d, dy_q, dy_d;
    logic [2:0]      grant_d, done_d, colour_d;
    logic            busy_d, plot_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;

    // Coordinates and size of the currently selected requester
    logic [XW-1:0]   in_ox, in_nx, in_wm1;
    logic [YW-1:0]   in_oy, in_ny, in_hm1;
    logic            in_same, last_pix;

    // First set request bit searching upward from the pointer, mod 3
    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
        logic [1:0] a, b, c;
        case (p)
            2'd1:    begin a = 2'd1; b = 2'd2; c = 2'd0; end
            2'd2:    begin a = 2'd2; b = 2'd0; c = 2'd1; end
            default: begin a = 2'd0; b = 2'd1; c = 2'd2; end
        endcase
        if (r[a])      return a;
        else if (r[b]) return b;
        else           return c;
    endfunction

    // Select coordinate fields and rectangle size of the served sprite
    always_comb begin
        in_ox  = old_x[8:0];
        in_oy  = old_y[7:0];
        in_nx  = new_x[8:0];
        in_ny  = new_y[7:0];
        in_wm1 = WM1_0;
        in_hm1 = HM1_0;
        case (sel_q)
            2'd1: begin
                in_ox  = old_x[17:9];
                in_oy  = old_y[15:8];
                in_nx  = new_x[17:9];
                in_ny  = new_y[15:8];
                in_wm1 = WM1_1;
                in_hm1 = HM1_1;
            end
            2'd2: begin
                in_ox  = old_x[26:18];
                in_oy  = old_y[23:16];
                in_nx  = new_x[26:18];
                in_ny  = new_y[23:16];
                in_wm1 = WM1_2;
                in_hm1 = HM1_2;
            end
            default: ;
        endcase
        in_same  = (in_ox == in_nx) && (in_oy == in_ny);
        last_pix = (dx_q == wm1_q) && (dy_q == hm1_q);
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req != 3'b000) state_d = S_LATCH;
            S_LATCH: state_d = in_same ? S_DRAW : S_ERASE;
            S_ERASE: if (last_pix) state_d = S_DRAW;
            S_DRAW:  if (last_pix) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; pixel outputs come from the next scan position
    always_comb begin
        logic [XW-1:0] bx;
        logic [YW-1:0] by;
        logic [2:0]    col;
        logic          pix_en;
        logic [XW:0]   xs;
        logic [YW:0]   ys;

        grant_d  = 3'b000;
        done_d   = 3'b000;
        busy_d   = (state_d != S_IDLE);
        plot_d   = 1'b0;
        x_d      = x;
        y_d      = y;
        colour_d = colour;
        ptr_d    = ptr_q;
        sel_d    = sel_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        nx_d     = nx_q;
        ny_d     = ny_q;
        wm1_d    = wm1_q;
        hm1_d    = hm1_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        bx       = nx_q;
        by       = ny_q;
        col      = FG_COLOUR;
        pix_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req != 3'b000) begin
                    sel_d   = rr_pick(ptr_q, req);
                    grant_d = 3'(3'b001 << sel_d);
                end
            end
            S_LATCH: begin
                ox_d   = in_ox;
                oy_d   = in_oy;
                nx_d   = in_nx;
                ny_d   = in_ny;
                wm1_d  = in_wm1;
                hm1_d  = in_hm1;
                dx_d   = '0;
                dy_d   = '0;
                pix_en = 1'b1;
                if (in_same) begin
                    bx  = in_nx;
                    by  = in_ny;
                    col = FG_COLOUR;
                end else begin
                    bx  = in_ox;
                    by  = in_oy;
                    col = BG_COLOUR;
                end
            end
            S_ERASE: begin
                pix_en = 1'b1;
                if (last_pix) begin
                    dx_d = '0;
                    dy_d = '0;
                    bx   = nx_q;
                    by   = ny_q;
                    col  = FG_COLOUR;
                end else begin
                    if (dx_q == wm1_q) begin
                        dx_d = '0;
                        dy_d = dy_q + YW'(1);
                    end else begin
                        dx_d = dx_q + XW'(1);
                    end
                    bx  = ox_q;
                    by  = oy_q;
                    col = BG_COLOUR;
                end
            end
            S_DRAW: begin
                if (last_pix) begin
                    done_d = 3'(3'b001 << sel_q);
                end else begin
                    pix_en = 1'b1;
                    if (dx_q == wm1_q) begin
                        dx_d = '0;
                        dy_d = dy_q + YW'(1);
                    end else begin
                        dx_d = dx_q + XW'(1);
                    end
                end
            end
            S_DONE: begin
                ptr_d = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            end
            default: ;
        endcase

        // Sum one bit wider so off-screen pixels can be suppressed
        xs = {1'b0, bx} + {1'b0, dx_d};
        ys = {1'b0, by} + {1'b0, dy_d};
        if (pix_en) begin
            x_d      = xs[XW-1:0];
            y_d      = ys[YW-1:0];
            colour_d = col;
            plot_d   = (xs < X_LIMIT) && (ys < Y_LIMIT);
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q  <= 2'd0;
            sel_q  <= 2'd0;
            ox_q   <= '0;
            oy_q   <= '0;
            nx_q   <= '0;
            ny_q   <= '0;
            wm1_q  <= '0;
            hm1_q  <= '0;
            dx_q   <= '0;
            dy_q   <= '0;
            grant  <= 3'b000;
            done   <= 3'b000;
            busy   <= 1'b0;
            x      <= '0;
            y      <= '0;
            colour <= 3'b000;
            plot   <= 1'b0;
        end else begin
            ptr_q  <= ptr_d;
            sel_q  <= sel_d;
            ox_q   <= ox_d;
            oy_q   <= oy_d;
            nx_q   <= nx_d;
            ny_q   <= ny_d;
            wm1_q  <= wm1_d;
            hm1_q  <= hm1_d;
            dx_q   <= dx_d;
            dy_q   <= dy_d;
            grant  <= grant_d;
            done   <= done_d;
            busy   <= busy_d;
            x      <= x_d;
            y      <= y_d;
            colour <= colour_d;
            plot   <= plot_d;
        end
    end

endmodule

// File: tb/tb_pong_draw_arbiter.sv
// Directed bench for pong_draw_arbiter: erase/draw scan, erase skip, clipping,
// round-robin order, async reset abort and req drop mid-operation.
module tb_pong_draw_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [26:0] old_x, new_x;
    logic [23:0] old_y, new_y;
    logic [2:0]  grant, done, colour;
    logic        busy, plot;
    logic [8:0]  x;
    logic [7:0]  y;

    int total = 0;
    int bad   = 0;

    pong_draw_arbiter dut (
        .clock  (clock),
        .reset  (reset),
        .req    (req),
        .old_x  (old_x),
        .old_y  (old_y),
        .new_x  (new_x),
        .new_y  (new_y),
        .grant  (grant),
        .done   (done),
        .busy   (busy),
        .x      (x),
        .y      (y),
        .colour (colour),
        .plot   (plot)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic pix(input string tag, input int ex, input int ey, input int ec, input int ep);
        chk({tag, " plot"},   32'(plot),   32'(ep));
        chk({tag, " x"},      32'(x),      32'(ex));
        chk({tag, " y"},      32'(y),      32'(ey));
        chk({tag, " colour"}, 32'(colour), 32'(ec));
    endtask

    task automatic set_sprite(input int i, input int ox, input int oy, input int nx, input int ny);
        old_x[i*9 +: 9] = 9'(ox);
        old_y[i*8 +: 8] = 8'(oy);
        new_x[i*9 +: 9] = 9'(nx);
        new_y[i*8 +: 8] = 8'(ny);
    endtask

    // Raise req, run to the done pulse, tally plotted pixels by colour
    task automatic run_op(input logic [2:0] r, input int drop_at, input int maxc,
                          output int gc, output logic [2:0] gv,
                          output int dc, output logic [2:0] dv,
                          output int nbg, output int nfg);
        gc = -1; gv = 3'b000; dc = -1; dv = 3'b000; nbg = 0; nfg = 0;
        req = r;
        for (int c = 1; c <= maxc; c++) begin
            tick();
            if (grant != 3'b000 && gc < 0) begin gc = c; gv = grant; end
            if (plot) begin
                if (colour == 3'b000) nbg++;
                else if (colour == 3'b111) nfg++;
            end
            if (drop_at > 0 && c == drop_at) req = 3'b000;
            if (done != 3'b000) begin dc = c; dv = done; req = 3'b000; break; end
        end
        req = 3'b000;
    endtask

    int          gc, dc, nbg, nfg, cyc, ng, nd;
    logic [2:0]  gv, dv;
    int          gcyc[4];
    logic [2:0]  gsel[4];
    int          dcyc[3];

    initial begin
        reset = 1'b1;
        req   = 3'b000;
        old_x = '0; old_y = '0; new_x = '0; new_y = '0;
        tick(); tick();
        chk("rst grant", 32'(grant), 32'd0);
        chk("rst done",  32'(done),  32'd0);
        chk("rst busy",  32'(busy),  32'd0);
        pix("rst", 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Ball erase at (10,10), draw at (11,10)
        set_sprite(2, 10, 10, 11, 10);
        set_sprite(0, 20, 50, 20, 54);
        set_sprite(1, 300, 100, 300, 104);
        req = 3'b100;
        tick();
        chk("b1 grant", 32'(grant), 32'd4);
        chk("b1 busy",  32'(busy),  32'd1);
        chk("b1 plot0", 32'(plot),  32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            pix("b1 erase", 10 + i % 4, 10 + i / 4, 0, 1);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            pix("b1 draw", 11 + i % 4, 10 + i / 4, 7, 1);
        end
        tick();
        chk("b1 done", 32'(done), 32'd4);
        pix("b1 hold", 14, 13, 7, 0);
        req = 3'b000;
        tick();
        chk("b1 idle busy", 32'(busy), 32'd0);
        chk("b1 idle done", 32'(done), 32'd0);

        // Unmoved ball: erase skipped
        set_sprite(2, 50, 60, 50, 60);
        run_op(3'b100, 0, 100, gc, gv, dc, dv, nbg, nfg);
        chk("skip grant cyc", 32'(gc), 32'd1);
        chk("skip done cyc",  32'(dc), 32'd18);
        chk("skip done",      32'(dv), 32'd4);
        chk("skip bg px",     32'(nbg), 32'd0);
        chk("skip fg px",     32'(nfg), 32'd16);
        tick();
        chk("skip idle busy", 32'(busy), 32'd0);

        // Ball at the bottom-right corner: only four pixels on screen
        set_sprite(2, 318, 238, 318, 238);
        req = 3'b100;
        tick();
        chk("clip grant", 32'(grant), 32'd4);
        for (int i = 0; i < 16; i++) begin
            tick();
            pix("clip", 318 + i % 4, (238 + i / 4) % 256, 7,
                ((i % 4) < 2 && (i / 4) < 2) ? 1 : 0);
        end
        tick();
        chk("clip done", 32'(done), 32'd4);
        req = 3'b000;
        tick();

        // Paddle 1 with req dropped two cycles after grant
        run_op(3'b010, 3, 400, gc, gv, dc, dv, nbg, nfg);
        chk("drop grant",     32'(gv), 32'd2);
        chk("drop done cyc",  32'(dc), 32'd258);
        chk("drop done",      32'(dv), 32'd2);
        chk("drop bg px",     32'(nbg), 32'd128);
        chk("drop fg px",     32'(nfg), 32'd128);
        tick();
        chk("drop idle busy", 32'(busy), 32'd0);

        // All three requesting after reset: round-robin 0,1,2,0
        set_sprite(2, 10, 10, 11, 10);
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        req = 3'b111;
        ng = 0; nd = 0; cyc = 0;
        for (int k = 0; k < 4; k++) begin gcyc[k] = -1; gsel[k] = 3'b000; end
        for (int k = 0; k < 3; k++) dcyc[k] = -1;
        while (cyc < 700 && ng < 4) begin
            tick();
            cyc++;
            if (grant != 3'b000) begin gcyc[ng] = cyc; gsel[ng] = grant; ng++; end
            if (done != 3'b000 && nd < 3) begin dcyc[nd] = cyc; nd++; end
        end
        chk("rr g0",     32'(gsel[0]), 32'd1);
        chk("rr g1",     32'(gsel[1]), 32'd2);
        chk("rr g2",     32'(gsel[2]), 32'd4);
        chk("rr g3",     32'(gsel[3]), 32'd1);
        chk("rr g0 cyc", 32'(gcyc[0]), 32'd1);
        chk("rr g1 cyc", 32'(gcyc[1]), 32'd260);
        chk("rr g2 cyc", 32'(gcyc[2]), 32'd519);
        chk("rr g3 cyc", 32'(gcyc[3]), 32'd554);
        chk("rr d0 cyc", 32'(dcyc[0]), 32'd258);
        chk("rr d1 cyc", 32'(dcyc[1]), 32'd517);
        chk("rr d2 cyc", 32'(dcyc[2]), 32'd552);

        // Into paddle 0 DRAW, then reset asynchronously
        for (int i = 0; i < 139; i++) tick();
        chk("mid draw plot",   32'(plot),   32'd1);
        chk("mid draw colour", 32'(colour), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("async grant", 32'(grant), 32'd0);
        chk("async done",  32'(done),  32'd0);
        chk("async busy",  32'(busy),  32'd0);
        pix("async", 0, 0, 0, 0);
        req = 3'b011;
        tick(); tick();
        chk("rst hold done", 32'(done), 32'd0);
        reset = 1'b0;

        // Pointer restarts at 0 and paddle 0 gets a full redraw
        run_op(3'b011, 0, 400, gc, gv, dc, dv, nbg, nfg);
        chk("post grant cyc", 32'(gc), 32'd1);
        chk("post grant",     32'(gv), 32'd1);
        chk("post done cyc",  32'(dc), 32'd258);
        chk("post done",      32'(dv), 32'd1);
        chk("post bg px",     32'(nbg), 32'd128);
        chk("post fg px",     32'(nfg), 32'd128);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
